// File: rtl/proj_pkg.sv
// Project-wide constants shared between the k-mer buffer and the murmur hasher.
package proj_pkg;
    parameter int KMER_BUFFER_HASHER_KMER_LEN  = 16;
    parameter int KMER_BUFFER_HASHER_BASE_BITS = 2;
endpackage

// File: rtl/kmer_buffer.sv
// Sliding k-mer window feeding the murmur hasher: packs the last KMER_LEN bases
// of a sequence into one word per accepted base once the window is full.
module kmer_buffer #(
    parameter int KMER_LEN         = proj_pkg::KMER_BUFFER_HASHER_KMER_LEN,
    parameter int BASE_BITS        = proj_pkg::KMER_BUFFER_HASHER_BASE_BITS,
    parameter int HASHER_DATA_BITS = KMER_LEN * BASE_BITS,
    parameter int IDX_BITS         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        base_valid,
    output logic                        base_ready,
    input  logic [BASE_BITS-1:0]        base_data,
    input  logic                        base_last,
    output logic                        kmer_valid,
    input  logic                        kmer_ready,
    output logic [HASHER_DATA_BITS-1:0] kmer_data,
    output logic                        kmer_last,
    output logic [IDX_BITS-1:0]         kmer_index,
    output logic                        short_seq
);

    localparam int CNT_BITS = (KMER_LEN > 1) ? $clog2(KMER_LEN) : 1;
    localparam logic [CNT_BITS-1:0] LAST_FILL = CNT_BITS'(KMER_LEN - 1);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic [CNT_BITS-1:0]         fill_cnt_r, fill_cnt_nxt_s;
    logic [HASHER_DATA_BITS-1:0] window_r, window_nxt_s, window_shift_s;
    logic [IDX_BITS-1:0]         seq_idx_r, seq_idx_nxt_s;
    logic                        kmer_valid_r, kmer_valid_nxt_s;
    logic [HASHER_DATA_BITS-1:0] kmer_data_r, kmer_data_nxt_s;
    logic                        kmer_last_r, kmer_last_nxt_s;
    logic [IDX_BITS-1:0]         kmer_index_r, kmer_index_nxt_s;
    logic                        short_seq_r, short_seq_nxt_s;
    logic                        accept_s, in_stream_s, emit_s;

    assign base_ready     = !rst && (!kmer_valid_r || kmer_ready);
    assign accept_s       = base_valid && base_ready;
    // A full window also covers KMER_LEN=1, where FILL never has to wait.
    assign in_stream_s    = (state_r == STREAM) || (fill_cnt_r == LAST_FILL);
    assign emit_s         = accept_s && in_stream_s;
    assign window_shift_s = (window_r << BASE_BITS) | HASHER_DATA_BITS'(base_data);

    assign kmer_valid = kmer_valid_r;
    assign kmer_data  = kmer_data_r;
    assign kmer_last  = kmer_last_r;
    assign kmer_index = kmer_index_r;
    assign short_seq  = short_seq_r;

    // Next-state, window and output-register load logic.
    always_comb begin
        state_nxt_s      = state_r;
        fill_cnt_nxt_s   = fill_cnt_r;
        window_nxt_s     = window_r;
        seq_idx_nxt_s    = seq_idx_r;
        kmer_valid_nxt_s = kmer_valid_r;
        kmer_data_nxt_s  = kmer_data_r;
        kmer_last_nxt_s  = kmer_last_r;
        kmer_index_nxt_s = kmer_index_r;
        short_seq_nxt_s  = 1'b0;

        if (emit_s) begin
            kmer_valid_nxt_s = 1'b1;
            kmer_data_nxt_s  = window_shift_s;
            kmer_last_nxt_s  = base_last;
            kmer_index_nxt_s = seq_idx_r;
            if (seq_idx_r == {IDX_BITS{1'b1}}) begin
                seq_idx_nxt_s = seq_idx_r;
            end else begin
                seq_idx_nxt_s = seq_idx_r + IDX_BITS'(1);
            end
        end else if (kmer_ready) begin
            kmer_valid_nxt_s = 1'b0;
        end else begin
            kmer_valid_nxt_s = kmer_valid_r;
        end

        // A sequence end overrides the window advance and restarts the fill.
        if (accept_s && base_last) begin
            state_nxt_s     = FILL;
            fill_cnt_nxt_s  = '0;
            window_nxt_s    = '0;
            seq_idx_nxt_s   = '0;
            short_seq_nxt_s = !in_stream_s;
        end else if (accept_s) begin
            window_nxt_s = window_shift_s;
            case (state_r)
                FILL: begin
                    if (!in_stream_s) begin
                        fill_cnt_nxt_s = fill_cnt_r + CNT_BITS'(1);
                        if (fill_cnt_r == (LAST_FILL - CNT_BITS'(1))) begin
                            state_nxt_s = STREAM;
                        end else begin
                            state_nxt_s = FILL;
                        end
                    end else begin
                        state_nxt_s = STREAM;
                    end
                end
                STREAM:  state_nxt_s = STREAM;
                default: state_nxt_s = FILL;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, window and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= FILL;
            fill_cnt_r   <= '0;
            window_r     <= '0;
            seq_idx_r    <= '0;
            kmer_valid_r <= 1'b0;
            kmer_data_r  <= '0;
            kmer_last_r  <= 1'b0;
            kmer_index_r <= '0;
            short_seq_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fill_cnt_r   <= fill_cnt_nxt_s;
            window_r     <= window_nxt_s;
            seq_idx_r    <= seq_idx_nxt_s;
            kmer_valid_r <= kmer_valid_nxt_s;
            kmer_data_r  <= kmer_data_nxt_s;
            kmer_last_r  <= kmer_last_nxt_s;
            kmer_index_r <= kmer_index_nxt_s;
            short_seq_r  <= short_seq_nxt_s;
        end
    end

endmodule

// File: tb/tb_kmer_buffer.sv
// Scoreboard bench for kmer_buffer: a queue-based sliding-window model predicts
// every k-mer and short_seq pulse; a negedge monitor checks what the DUT presents.
module tb_kmer_buffer;
    localparam int K   = 16;
    localparam int BB  = 2;
    localparam int W   = 32;
    localparam int IDX = 4;
    localparam int IDX_MAX = (1 << IDX) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           base_valid = 1'b0;
    logic           base_ready;
    logic [BB-1:0]  base_data = '0;
    logic           base_last = 1'b0;
    logic           kmer_valid;
    logic           kmer_ready = 1'b0;
    logic [W-1:0]   kmer_data;
    logic           kmer_last;
    logic [IDX-1:0] kmer_index;
    logic           short_seq;

    kmer_buffer #(.IDX_BITS(IDX)) dut (
        .clk(clk), .rst(rst),
        .base_valid(base_valid), .base_ready(base_ready),
        .base_data(base_data), .base_last(base_last),
        .kmer_valid(kmer_valid), .kmer_ready(kmer_ready),
        .kmer_data(kmer_data), .kmer_last(kmer_last),
        .kmer_index(kmer_index), .short_seq(short_seq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           idx;
    } exp_t;

    exp_t exp_q[$];
    int   seq_q[$];
    int   seq_cnt = 0;
    bit   short_exp[int];
    int   n_acc = 0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the k-mer is the last K bases of the sequence, oldest in the MSBs.
    task automatic model_accept(input int b, input logic l);
        exp_t e;
        logic [W-1:0] w;
        seq_q.push_back(b);
        if (seq_q.size() > K) void'(seq_q.pop_front());
        seq_cnt++;
        n_acc++;
        if (seq_cnt >= K) begin
            w = '0;
            foreach (seq_q[i]) w = (w << BB) | W'(seq_q[i]);
            e.data = w;
            e.last = l;
            e.idx  = (seq_cnt - K > IDX_MAX) ? IDX_MAX : seq_cnt - K;
            exp_q.push_back(e);
        end
        if (l) begin
            if (seq_cnt < K) short_exp[cyc + 1] = 1'b1;
            seq_q.delete();
            seq_cnt = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        seq_q.delete();
        seq_cnt = 0;
        short_exp.delete();
    endtask

    // Monitor: handshake rule, short_seq pulse and every consumed k-mer.
    always @(negedge clk) begin
        check("base_ready_rule", 64'(base_ready), 64'(!rst && (!kmer_valid || kmer_ready)));
        check("short_seq", 64'(short_seq), 64'(short_exp.exists(cyc) ? 1 : 0));
        if (kmer_valid && kmer_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL kmer_unexpected: got data 0x%0h index %0d, expected no k-mer", kmer_data, kmer_index);
            end else begin
                mon_e = exp_q.pop_front();
                check("kmer_data", 64'(kmer_data), 64'(mon_e.data));
                check("kmer_last", 64'(kmer_last), 64'(mon_e.last));
                check("kmer_index", 64'(kmer_index), 64'(mon_e.idx));
            end
        end
    end

    task automatic step(input logic v, input logic [BB-1:0] d, input logic l, input logic r);
        base_valid = v;
        base_data  = d;
        base_last  = l;
        kmer_ready = r;
        @(negedge clk);
        if (base_valid && base_ready) model_accept(int'(base_data), base_last);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_kmer_valid"}, 64'(kmer_valid), 64'(0));
        check({tag, "_kmer_data"},  64'(kmer_data),  64'(0));
        check({tag, "_kmer_last"},  64'(kmer_last),  64'(0));
        check({tag, "_kmer_index"}, 64'(kmer_index), 64'(0));
        check({tag, "_short_seq"},  64'(short_seq),  64'(0));
        check({tag, "_base_ready"}, 64'(base_ready), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero(tag);
        base_valid = 1'b0;
        kmer_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fresh_fill(input string tag, input logic hold_last);
        for (int i = 0; i < K; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 1'b0, (i == K - 1) ? !hold_last : 1'b1);
            if (i == K - 2) check({tag, "_no_valid_before_16"}, 64'(kmer_valid), 64'(0));
        end
        check({tag, "_valid_at_16"}, 64'(kmer_valid), 64'(1));
    endtask

    initial begin
        int start_acc;
        int guard;
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Fill and stream with the 0,1,2,3 pattern.
        for (int i = 0; i < K; i++) begin
            step(1'b1, 2'(i % 4), 1'b0, 1'b1);
            if (i < K - 1) check("fill_no_valid", 64'(kmer_valid), 64'(0));
        end
        check("first_valid", 64'(kmer_valid), 64'(1));
        check("first_data", 64'(kmer_data), 64'h1B1B1B1B);
        check("first_index", 64'(kmer_index), 64'(0));
        step(1'b1, 2'd0, 1'b0, 1'b1);
        check("second_data", 64'(kmer_data), 64'h6C6C6C6C);
        check("second_index", 64'(kmer_index), 64'(1));
        check("second_last", 64'(kmer_last), 64'(0));

        // Backpressure: the pending k-mer holds and no base is taken.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd3, 1'b0, 1'b0);
            check("bp_base_ready", 64'(base_ready), 64'(0));
            check("bp_valid", 64'(kmer_valid), 64'(1));
            check("bp_data", 64'(kmer_data), 64'h6C6C6C6C);
            check("bp_index", 64'(kmer_index), 64'(1));
        end
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("bp_released", 64'(kmer_valid), 64'(0));

        // Exact-length sequences.
        step(1'b1, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < K; i++) step(1'b1, 2'd3, i == K - 1, 1'b1);
        check("exact_ff_data", 64'(kmer_data), 64'hFFFFFFFF);
        check("exact_ff_last", 64'(kmer_last), 64'(1));
        check("exact_ff_index", 64'(kmer_index), 64'(0));
        step(1'b1, 2'd1, 1'b0, 1'b1);
        for (int i = 0; i < K - 1; i++) step(1'b1, 2'd0, i == K - 2, 1'b1);
        check("exact_40_data", 64'(kmer_data), 64'h40000000);
        check("exact_40_last", 64'(kmer_last), 64'(1));
        check("exact_40_index", 64'(kmer_index), 64'(0));
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("exact_only_one", 64'(kmer_valid), 64'(0));

        // Short sequence.
        for (int i = 0; i < 5; i++) step(1'b1, 2'($urandom_range(0, 3)), i == 4, 1'b1);
        check("short_pulse", 64'(short_seq), 64'(1));
        check("short_no_kmer", 64'(kmer_valid), 64'(0));
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("short_pulse_end", 64'(short_seq), 64'(0));
        fresh_fill("after_short", 1'b0);

        // Reset mid-sequence, then with a k-mer held by backpressure.
        step(1'b1, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        do_reset("rst_mid");
        fresh_fill("rst_mid", 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        do_reset("rst_pending");
        fresh_fill("rst_pending", 1'b0);
        step(1'b1, 2'd0, 1'b1, 1'b1);

        // Randomized traffic against the model.
        start_acc = n_acc;
        guard = 0;
        while (n_acc < start_acc + 1000 && guard < 20000) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0);
            guard++;
        end
        check("random_bases_accepted", 64'(n_acc - start_acc >= 1000), 64'(1));

        guard = 0;
        while ((exp_q.size() != 0 || kmer_valid) && guard < 50) begin
            step(1'b0, 2'd0, 1'b0, 1'b1);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        check("drain_valid", 64'(kmer_valid), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/kmer_buffer.md
# kmer_buffer

Streaming k-mer window that sits directly upstream of the `murmur_4bytes` hasher. It accepts a DNA sequence one 2-bit-encoded base per cycle with a valid/ready handshake and keeps a sliding window of the last `KMER_LEN` bases. Once `KMER_LEN` bases of the current sequence are in the window, every further accepted base emits one packed k-mer word sized for the hasher's `kmer` input. It also handles sequence boundaries, short sequences and downstream backpressure.

## Interface
- `KMER_LEN`, default `proj_pkg::KMER_BUFFER_HASHER_KMER_LEN` (16): bases per k-mer.
- `BASE_BITS`, default `proj_pkg::KMER_BUFFER_HASHER_BASE_BITS` (2): bits per base.
- `HASHER_DATA_BITS`, default `KMER_LEN*BASE_BITS` (32): k-mer word width.
- `IDX_BITS`, default 16: width of the k-mer index counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `base_valid` in 1: upstream base available.
- `base_ready` out 1: block accepts a base this cycle.
- `base_data` in `BASE_BITS`: encoded base.
- `base_last` in 1: qualifies `base_data` as the final base of its sequence.
- `kmer_valid` out 1: `kmer_data` holds a valid k-mer.
- `kmer_ready` in 1: the hasher stage consumes the k-mer.
- `kmer_data` out `HASHER_DATA_BITS`: packed k-mer. The oldest base is in the MSBs and the newest base is in the LSBs.
- `kmer_last` out 1: this k-mer was produced by the sequence's last base.
- `kmer_index` out `IDX_BITS`: 0-based position of this k-mer within its sequence. Saturates at all-ones.
- `short_seq` out 1: one-cycle pulse when a sequence ends with fewer than `KMER_LEN` bases.

## Operation
- A base is accepted when `base_valid && base_ready`.
- `base_ready = !rst && (!kmer_valid || kmer_ready)`. This is combinational and applies in every state.
- The window register shifts on each accepted base: `window <= {window[HASHER_DATA_BITS-BASE_BITS-1:0], base_data}`.
- The fill counter `fill_cnt` runs from 0 to `KMER_LEN-1`.
- State FILL (`fill_cnt < KMER_LEN-1`):
  - An accepted base increments `fill_cnt`. No output is produced.
  - When `fill_cnt` reaches `KMER_LEN-1`, the state moves to STREAM.
- State STREAM:
  - Each accepted base loads `kmer_data` with the new window value (including that base) and sets `kmer_valid`.
  - `kmer_index` is loaded with the sequence k-mer counter, which then increments and saturates.
  - `kmer_last` is loaded with `base_last`.
- `base_last` on an accepted base, in either state:
  - The window is cleared to 0, `fill_cnt` is cleared to 0, the k-mer counter is cleared to 0, and the state goes to FILL.
  - In FILL, `short_seq` pulses high the next cycle.
  - In STREAM, the final k-mer is emitted normally with `kmer_last=1`.
- `kmer_valid` clears when `kmer_ready` is high and no new k-mer is loaded in the same cycle.
  - Simultaneous consume and load keeps `kmer_valid=1` with the new data, giving full throughput.
- The output register holds `kmer_data`, `kmer_last` and `kmer_index` stable while `kmer_valid && !kmer_ready`.
- Special case `KMER_LEN=1`: the FILL phase is empty and every base emits a k-mer.

## Timing
- Latency: 1 cycle from base acceptance to `kmer_valid`/`kmer_data`.
- Throughput: 1 base and 1 k-mer per cycle while `kmer_ready=1`.
- Reset (asynchronous, while `rst=1`):
  - `kmer_valid=0`, `kmer_data=0`, `kmer_last=0`, `kmer_index=0`, `short_seq=0`, `base_ready=0`.
  - State FILL, `fill_cnt=0`, window cleared to 0.
- First accept is possible on the first rising edge after `rst` deasserts.
- Reset asserted mid-sequence discards any partial window and any pending k-mer. The next sequence needs `KMER_LEN` fresh bases.
- `short_seq` is a registered pulse exactly 1 cycle wide. It does not depend on `kmer_ready`.
- `kmer_index` saturates at `2^IDX_BITS-1`; it never wraps.

## Test plan
- **Fill and stream:** feed 16 bases 0,1,2,3 repeated 4 times, then base 0, with `kmer_ready=1`.
  - No `kmer_valid` during the first 15 bases.
  - The cycle after the 16th base: `kmer_data=0x1B1B1B1B`, `kmer_index=0`.
  - The next cycle: `0x6C6C6C6C`, `kmer_index=1`.
- **Backpressure:** hold `kmer_ready=0` for 3 cycles while a k-mer is valid.
  - `base_ready=0` for those cycles.
  - `kmer_data` and `kmer_index` remain stable.
  - On release, the k-mer is consumed, with no loss and no duplicates.
- **Exact-length sequence:** 16 bases of value 3, with `base_last` on the 16th.
  - One k-mer `0xFFFFFFFF` with `kmer_last=1` and `kmer_index=0`.
  - Next, a base 1 followed by 15 bases of value 0 (16 bases, `base_last` on the last) yields exactly one k-mer `0x40000000`.
- **Short sequence:** 5 bases with `base_last` on the 5th.
  - No `kmer_valid`.
  - `short_seq` is high for exactly 1 cycle.
  - The following sequence emits its first k-mer only after 16 bases.
- **Reset mid-sequence:** assert `rst` after 10 bases, or while `kmer_valid=1` with `kmer_ready=0`.
  - All outputs go to 0 immediately (asynchronously).
  - After release, 16 new bases are required before the first `kmer_valid`.
- **Random stream versus model:** random `base_valid`/`kmer_ready` over 1000 bases with random `base_last`.
  - Every k-mer matches a reference sliding-window model.
  - `kmer_index` and `kmer_last` are correct for every k-mer.
